// File: rtl/packet_queue_pkg.sv
// Shared sizing defaults for the elastic packet queue between loader and executor.
// Optional combinational bypass is enabled by defining PACKET_QUEUE_BYPASS_EN.
package packet_queue_pkg;

  // Mirrors PACKET_WIDTH in include/param.vh: five 32-bit words plus a 15-bit tail.
  localparam int PQ_PACKET_WIDTH = 175;
  localparam int PQ_DEPTH_LOG2   = 3;

  function automatic int pq_depth(input int depth_log2);
    return 1 << depth_log2;
  endfunction

endpackage

// File: rtl/packet_queue_mem.sv
// Packet storage: DEPTH x WIDTH register array, one synchronous write port,
// one asynchronous read port. Contents are deliberately not reset.
module packet_queue_mem
  import packet_queue_pkg::*;
#(
  parameter int WIDTH      = PQ_PACKET_WIDTH,
  parameter int DEPTH_LOG2 = PQ_DEPTH_LOG2
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);

  localparam int DEPTH = pq_depth(DEPTH_LOG2);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/packet_queue.sv
// Elastic in-order packet buffer between the packet loader and the executor.
// Define PACKET_QUEUE_BYPASS_EN for a zero-latency pass-through when empty.
module packet_queue
  import packet_queue_pkg::*;
#(
  parameter int PACKET_WIDTH = PQ_PACKET_WIDTH,
  parameter int DEPTH_LOG2   = PQ_DEPTH_LOG2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    RECEIVE_PC_VALID,
  input  logic [PACKET_WIDTH-1:0] RECEIVE_PC_DATA,
  output logic                    RECEIVE_PC_READY,
  output logic                    SEND_PC_VALID,
  output logic [PACKET_WIDTH-1:0] SEND_PC_DATA,
  input  logic                    SEND_PC_READY,
  output logic [DEPTH_LOG2:0]     COUNT
);

  localparam int PTR_W = DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(pq_depth(DEPTH_LOG2));

  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    full, empty, push, pop;
  logic [PACKET_WIDTH-1:0] head_data;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Ready depends only on registered state, so a full queue refuses even when
  // the executor pops in the same cycle.
  assign RECEIVE_PC_READY = !full;
  assign pop              = !empty && SEND_PC_READY;

`ifdef PACKET_QUEUE_BYPASS_EN
  logic pass_through;
  assign pass_through  = empty && RECEIVE_PC_VALID && SEND_PC_READY;
  assign push          = RECEIVE_PC_VALID && !full && !pass_through;
  assign SEND_PC_VALID = !empty || RECEIVE_PC_VALID;
  assign SEND_PC_DATA  = empty ? RECEIVE_PC_DATA : head_data;
`else
  assign push          = RECEIVE_PC_VALID && !full;
  assign SEND_PC_VALID = !empty;
  assign SEND_PC_DATA  = head_data;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign COUNT = count_q;

  packet_queue_mem #(
    .WIDTH      (PACKET_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk_i   (CLK),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (RECEIVE_PC_DATA),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_data)
  );

endmodule

// File: doc/packet_queue.md
# packet_queue

Elastic packet buffer between the packet loader's queue-bound output (opmode EI packets) and the executor's packet input. Absorbs the six-word memory-read latency of the loader so execution-ready packets are never dropped and the loader is never stalled while the executor is busy. Packets are stored whole (one PACKET_WIDTH entry each) and issued in strict arrival order.

## Interface
- PACKET_WIDTH, 175: packet width in bits (five 32-bit words plus 15-bit tail); value comes from include/param.vh.
- DEPTH_LOG2, 3: log2 of the entry count; DEPTH = 2**DEPTH_LOG2 (default 8).

- CLK  in  1  clock, all state changes on rising edge.
- RST  in  1  asynchronous, active-low reset.
- RECEIVE_PC_VALID  in  1  loader presents a packet.
- RECEIVE_PC_DATA  in  PACKET_WIDTH  packet from loader.
- RECEIVE_PC_READY  out  1  queue can accept a packet this cycle.
- SEND_PC_VALID  out  1  head packet available to executor.
- SEND_PC_DATA  out  PACKET_WIDTH  head packet.
- SEND_PC_READY  in  1  executor accepts head.
- COUNT  out  DEPTH_LOG2+1  entries currently held, 0..DEPTH.

## Operation
- Push: RECEIVE_PC_VALID && RECEIVE_PC_READY at a rising edge writes RECEIVE_PC_DATA at wr_ptr, wr_ptr+1.
- Pop: SEND_PC_VALID && SEND_PC_READY at a rising edge retires head, rd_ptr+1.
- Pointers DEPTH_LOG2 bits, wrap modulo DEPTH; COUNT is a separate register: +1 on push only, -1 on pop only, unchanged on both or neither.
- RECEIVE_PC_READY = (COUNT != DEPTH); derived from registered state only, never from SEND_PC_READY.
- SEND_PC_VALID = (COUNT != 0); SEND_PC_DATA = storage[rd_ptr].
- Full: push blocked even if a pop occurs the same cycle (no push-through-full).
- Empty: SEND_PC_DATA don't-care; SEND_PC_VALID low.
- Simultaneous push and pop with 0 < COUNT < DEPTH: both complete, COUNT unchanged.
- Packet content is never altered; data bits X-free when valid.
- Valid/ready contract: once SEND_PC_VALID is high it stays high with stable data until a pop.

## Timing
- Reset (RST low, asynchronous): wr_ptr=0, rd_ptr=0, COUNT=0, SEND_PC_VALID=0, RECEIVE_PC_READY=1 (asserted as soon as RST is low, held after release). Storage contents not reset.
- Reset mid-operation discards all held packets immediately; no partial pop.
- Latency: packet pushed at edge N is visible on SEND_PC_VALID/SEND_PC_DATA after edge N, poppable at edge N+1.
- Throughput: one push and one pop per cycle sustained.
- RECEIVE_PC_READY rises the cycle after the pop that leaves the queue non-full.

## Configuration
- PACKET_QUEUE_BYPASS_EN defined: when COUNT==0 and RECEIVE_PC_VALID is high, SEND_PC_VALID is driven high combinationally and SEND_PC_DATA = RECEIVE_PC_DATA; if SEND_PC_READY is also high, the packet passes through with zero latency and is not written (pointers and COUNT unchanged). If SEND_PC_READY is low, a normal push occurs.
- Undefined: strictly one-cycle minimum latency as in Timing; no combinational input-to-output path.

## Structure
- PACKET_WIDTH and the OPCODE_*/DEST_OPTION_* constants stay in include/param.vh; packet field helpers stay in include/construct.vh. No new constants are added to either.
- One sub-module: packet_queue_mem — DEPTH x PACKET_WIDTH register array, one synchronous write port, one asynchronous read port. Pointer/count control lives in packet_queue.

## Test plan
- Reset: RST low with RECEIVE_PC_VALID=1 -> RECEIVE_PC_READY=1, SEND_PC_VALID=0, COUNT=0; no write occurs.
- Single packet: push random packet P at edge N, SEND_PC_READY=0 -> after N, SEND_PC_VALID=1, SEND_PC_DATA===P, COUNT=1; stays stable for 5 cycles; pop -> COUNT=0.
- Fill/overflow: push 9 packets with SEND_PC_READY=0 -> first 8 accepted, COUNT=8, RECEIVE_PC_READY=0, ninth held by loader; pop one -> ninth accepted next cycle; drain returns all 9 in order.
- Wrap: 20 push/pop cycles with SEND_PC_READY=1, both valid every cycle -> COUNT stays at 1, output order matches input order across pointer wrap.
- Full plus simultaneous pop: COUNT=8, RECEIVE_PC_VALID=1, SEND_PC_READY=1 -> only pop, COUNT=7.
- Bypass (PACKET_QUEUE_BYPASS_EN only): empty queue, P valid, SEND_PC_READY=1 -> SEND_PC_DATA===P same cycle, COUNT stays 0; without macro, P appears one cycle later.
